// File: rtl/ma_seq.sv
// ma_seq: sequential N x N unsigned multiplier.
// A single ma_row adder row is reused for N clock cycles, one multiplier bit
// per cycle, instead of building a full N-row array.
// Optional feature: define MA_SEQ_EARLY_EXIT_EN to finish as soon as the
// multiplier bits still to be processed are all zero (and to skip RUN
// entirely when b == 0). The default build always runs exactly N steps.

// One add row: so = si + (y ? x : 0), with the carry out in so[N].
module ma_row #(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic         y,
  input  logic [N-1:0] si,
  output logic [N:0]   so
);

  // Ripple a single add of the gated multiplicand onto the running high half.
  always_comb begin
    logic c;
    logic xy;
    // NOTE: every variable gets a value before any branch or loop so no latch is inferred.
    c  = 1'b0;
    xy = 1'b0;
    so = '0;
    for (int i = 0; i < N; i++) begin
      xy    = x[i] & y;
      so[i] = si[i] ^ xy ^ c;
      c     = (si[i] & xy) | (si[i] & c) | (xy & c);
    end
    so[N] = c;
  end

endmodule

module ma_seq #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p,
  output logic           busy
);

  localparam int KW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   areg;
  logic [2*N-1:0] preg;
  logic [KW-1:0]  k;

  logic [N:0]     so;
  logic [2*N-1:0] next_preg;
  logic           last_step;

  // The shared row: multiplicand, current multiplier bit, running high half.
  ma_row #(.N(N)) u_row (
    .x  (areg),
    .y  (preg[0]),
    .si (preg[2*N-1:N]),
    .so (so)
  );

  // The row sum becomes the new high half; the consumed multiplier bit drops off.
  assign next_preg = {so, preg[N-1:1]};
  assign last_step = (k == KW'(N - 1));
  assign p         = preg;

`ifdef MA_SEQ_EARLY_EXIT_EN
  logic           rem_zero;
  logic [KW-1:0]  shamt;
  logic [2*N-1:0] exit_preg;

  // Detect that the multiplier bits still unprocessed after this step are zero,
  // and pre-align the product as if the remaining zero steps had been run.
  always_comb begin
    rem_zero = 1'b1;
    for (int i = 0; i < N - 1; i++) begin
      if ((i + int'(k) <= N - 2) && next_preg[i]) rem_zero = 1'b0;
    end
    shamt     = KW'(N - 1) - k;
    exit_preg = next_preg >> shamt;
  end
`endif

  // Control FSM plus datapath registers; handshake outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      areg      <= '0;
      preg      <= '0;
      k         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (state)
        IDLE: begin
          if (in_valid) begin
            areg     <= a;
            k        <= '0;
            in_ready <= 1'b0;
`ifdef MA_SEQ_EARLY_EXIT_EN
            if (b == '0) begin
              preg      <= '0;
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              preg  <= {{N{1'b0}}, b};
              state <= RUN;
              busy  <= 1'b1;
            end
`else
            preg  <= {{N{1'b0}}, b};
            state <= RUN;
            busy  <= 1'b1;
`endif
          end
        end

        RUN: begin
          preg <= next_preg;
          k    <= k + 1'b1;
          if (last_step) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
`ifdef MA_SEQ_EARLY_EXIT_EN
          else if (rem_zero) begin
            preg      <= exit_preg;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
`endif
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ma_seq.sv
// tb_ma_seq: scoreboard bench for ma_seq.
// An N=4 instance runs directed scenarios; an N=8 instance runs random traffic.
// Expected products go into per-instance queues at accept time; monitors pop
// and compare on every output handshake.
module tb_ma_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // N=4 instance
  logic       in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [3:0] a4, b4;
  logic [7:0] p4;

  // N=8 instance
  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  int total = 0;
  int bad   = 0;
  int unsigned q4[$];
  int unsigned q8[$];

  ma_seq #(.N(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .p         (p4),
    .busy      (busy4)
  );

  ma_seq #(.N(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .p         (p8),
    .busy      (busy8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Edges from the accept edge until out_valid is seen. Early exit finishes
  // right after the step that consumes the highest set bit of b; b == 0 goes
  // straight to DONE on the accept edge itself.
  function automatic int exp_lat(input int unsigned bv, input int n);
    int r;
    r = n;
`ifdef MA_SEQ_EARLY_EXIT_EN
    r = 0;
    for (int i = 0; i < n; i++) if (bv[i]) r = i + 1;
`endif
    return r;
  endfunction

  // Scoreboard monitor, N=4 instance.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid4 && out_ready4) begin
      if (q4.size() == 0) begin
        total++; bad++;
        $display("FAIL p4 unexpected output: got %0d expected none", p4);
      end else begin
        check("p4 scoreboard", 64'(p4), 64'(q4.pop_front()));
      end
    end
  end

  // Scoreboard monitor, N=8 instance.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid8 && out_ready8) begin
      if (q8.size() == 0) begin
        total++; bad++;
        $display("FAIL p8 unexpected output: got %0d expected none", p8);
      end else begin
        check("p8 scoreboard", 64'(p8), 64'(q8.pop_front()));
      end
    end
  end

  // Present operands for one cycle; returns at the negedge after the accept edge.
  task automatic issue4(input logic [3:0] av, input logic [3:0] bv);
    @(negedge clk);
    in_valid4 = 1'b1;
    a4 = av;
    b4 = bv;
    check("in_ready4 before accept", 64'(in_ready4), 64'd1);
    q4.push_back(int'(av) * int'(bv));
    @(negedge clk);
    in_valid4 = 1'b0;
    a4 = 4'($urandom);
    b4 = 4'($urandom);
  endtask

  task automatic wait_out4(output int lat);
    lat = 0;
    while (!out_valid4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int accepted;
    int cycles;
    int c;

    rst_n = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
    #12;
    check("reset in_ready", 64'(in_ready4), 64'd1);
    check("reset out_valid", 64'(out_valid4), 64'd0);
    check("reset busy", 64'(busy4), 64'd0);
    check("reset p", 64'(p4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 15*15 with out_ready high: 1-cycle pulse.
    out_ready4 = 1'b1;
    issue4(4'd15, 4'd15);
    check("t1 busy", 64'(busy4), 64'd1);
    wait_out4(lat);
    check("t1 latency", 64'(lat), 64'(exp_lat(15, 4)));
    check("t1 p", 64'(p4), 64'd225);
    @(negedge clk);
    check("t1 pulse width", 64'(out_valid4), 64'd0);
    check("t1 back to idle", 64'(in_ready4), 64'd1);

    // 13*11 with out_ready held low: result held, new requests ignored.
    out_ready4 = 1'b0;
    issue4(4'd13, 4'd11);
    wait_out4(lat);
    check("t2 latency", 64'(lat), 64'(exp_lat(11, 4)));
    check("t2 p", 64'(p4), 64'd143);
    repeat (5) begin
      @(negedge clk);
      check("t2 hold p", 64'(p4), 64'd143);
      check("t2 hold out_valid", 64'(out_valid4), 64'd1);
      check("t2 hold in_ready", 64'(in_ready4), 64'd0);
      in_valid4 = 1'b1;
      a4 = 4'($urandom);
      b4 = 4'($urandom);
    end
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    @(negedge clk);
    check("t2 release out_valid", 64'(out_valid4), 64'd0);
    check("t2 release in_ready", 64'(in_ready4), 64'd1);
    check("t2 release busy", 64'(busy4), 64'd0);

    // Zero operands.
    issue4(4'd0, 4'd9);
    wait_out4(lat);
    check("t3a latency", 64'(lat), 64'(exp_lat(9, 4)));
    check("t3a p", 64'(p4), 64'd0);
    @(negedge clk);
    issue4(4'd9, 4'd0);
    wait_out4(lat);
    check("t3b latency", 64'(lat), 64'(exp_lat(0, 4)));
    check("t3b p", 64'(p4), 64'd0);
    @(negedge clk);

    // Reset in the middle of RUN, then a clean operation.
    issue4(4'd15, 4'd15);
    check("t4 busy before reset", 64'(busy4), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t4 reset busy", 64'(busy4), 64'd0);
    check("t4 reset out_valid", 64'(out_valid4), 64'd0);
    check("t4 reset p", 64'(p4), 64'd0);
    check("t4 reset in_ready", 64'(in_ready4), 64'd1);
    q4.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue4(4'd3, 4'd5);
    wait_out4(lat);
    check("t4 latency", 64'(lat), 64'(exp_lat(5, 4)));
    check("t4 p", 64'(p4), 64'd15);
    @(negedge clk);

    // 7*1: short with early exit, full length without.
    issue4(4'd7, 4'd1);
    wait_out4(lat);
    check("t5 latency", 64'(lat), 64'(exp_lat(1, 4)));
    check("t5 p", 64'(p4), 64'd7);
    @(negedge clk);
    check("q4 drained", 64'(q4.size()), 64'd0);

    // Random traffic on the N=8 instance.
    accepted = 0;
    cycles = 0;
    while (accepted < 1000 && cycles < 40000) begin
      @(negedge clk);
      cycles++;
      out_ready8 = 1'(($urandom % 4) != 0);
      in_valid8  = 1'($urandom % 2);
      a8 = 8'($urandom);
      b8 = (($urandom % 4) == 0) ? 8'($urandom % 4) : 8'($urandom);
      if (in_valid8 && (busy8 || out_valid8))
        check("r in_ready while busy", 64'(in_ready8), 64'd0);
      if (in_valid8 && in_ready8) begin
        q8.push_back(int'(a8) * int'(b8));
        accepted++;
      end
    end
    check("r accepted count", 64'(accepted), 64'd1000);
    @(negedge clk);
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    c = 0;
    while (q8.size() != 0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("q8 drained", 64'(q8.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
